// File: rtl/sha1_wb_pkg.sv
// Shared register map and codes for the SHA1 accelerator window; the
// accelerator and its bus host both import this.
package sha1_wb_pkg;
  localparam logic [31:0] OPS_OFF    = 32'h0000_0008;
  localparam logic [31:0] MSG_OFF    = 32'h0000_000C;
  localparam logic [31:0] DIGEST_OFF = 32'h0000_0010;

  localparam int OPS_ON    = 0;
  localparam int OPS_RESET = 1;
  localparam int OPS_PANIC = 2;
  localparam int OPS_DONE  = 3;

  localparam logic [31:0] CTRL_ID = 32'h5348_4131;

  typedef enum logic [1:0] {
    ERR_NONE        = 2'd0,
    ERR_ACK_TIMEOUT = 2'd1,
    ERR_POLL_LIMIT  = 2'd2
  } err_code_e;
endpackage

// File: rtl/sha1_wb_host_if.sv
// Wishbone initiator-side bus bundle between the SHA1 host and the register target.
interface sha1_wb_host_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_ack_i, wbm_dat_i
  );
  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_ack_i, wbm_dat_i
  );
endinterface

// File: rtl/sha1_wb_xfer.sv
// Single-transfer Wishbone initiator: one-cycle strobe, ack wait with timeout,
// and a guaranteed idle cycle after every transfer.
module sha1_wb_xfer #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        wb_clk_i,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack_done,
  output logic        timeout,
  sha1_wb_host_if.master wb
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  logic [TW-1:0] timer;

  // cyc doubles as the "transfer outstanding" state; acks outside it are ignored
  assign rdata    = wb.wbm_dat_i;
  assign ack_done = wb.wbm_cyc_o && wb.wbm_ack_i;
  assign timeout  = wb.wbm_cyc_o && !wb.wbm_ack_i && (timer == TW'(ACK_TIMEOUT));

  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      wb.wbm_cyc_o <= 1'b0;
      wb.wbm_stb_o <= 1'b0;
      wb.wbm_we_o  <= 1'b0;
      wb.wbm_sel_o <= 4'h0;
      wb.wbm_adr_o <= 32'h0;
      wb.wbm_dat_o <= 32'h0;
      timer        <= '0;
    end else if (!wb.wbm_cyc_o) begin
      timer <= '0;
      if (req) begin
        wb.wbm_cyc_o <= 1'b1;
        wb.wbm_stb_o <= 1'b1;
        wb.wbm_we_o  <= we;
        wb.wbm_sel_o <= 4'hF;
        wb.wbm_adr_o <= adr;
        wb.wbm_dat_o <= wdata;
      end
    end else begin
      // the target acts on every strobed cycle, so strobe never lasts past one
      wb.wbm_stb_o <= 1'b0;
      if (ack_done || timeout) begin
        wb.wbm_cyc_o <= 1'b0;
        wb.wbm_sel_o <= 4'h0;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end
endmodule

// File: rtl/sha1_wb_host.sv
// Drives the SHA1 accelerator register window: ON, 16 message words,
// DONE polling and a 5-word digest read, with abort on bus or poll failure.
module sha1_wb_host
  import sha1_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0024,
  parameter int          ACK_TIMEOUT  = 16,
  parameter int          POLL_LIMIT   = 1024
) (
  input  logic         wb_clk_i,
  input  logic         reset,
  input  logic         start,
  input  logic [511:0] msg_i,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [1:0]   error_code,
  output logic [159:0] digest_o,
  sha1_wb_host_if.master wb
);
  localparam int PW = $clog2(POLL_LIMIT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ON, S_MSG, S_POLL, S_DIG, S_FIN} state_e;

  state_e         st, nxt;
  logic [511:0]   msg_q;
  logic [159:0]   dig_q;
  logic [3:0]     idx;
  logic [PW-1:0]  poll_cnt;
  logic           req, we, ack_done, timeout;
  logic [31:0]    adr, wdata, rdata;
  logic           poll_abort;

  assign poll_abort = (st == S_POLL) && ack_done && !rdata[OPS_DONE] &&
                      (poll_cnt == PW'(POLL_LIMIT - 1));

  sha1_wb_xfer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_xfer (
    .wb_clk_i (wb_clk_i),
    .reset    (reset),
    .req      (req),
    .we       (we),
    .adr      (adr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ack_done (ack_done),
    .timeout  (timeout),
    .wb       (wb)
  );

  always_ff @(posedge wb_clk_i) begin
    if (reset) st <= S_IDLE;
    else       st <= nxt;
  end

  // req stays up through a whole bus state; the transfer engine only takes it
  // when idle, so the next request lands in the gap cycle after each ack
  always_comb begin
    nxt   = st;
    req   = 1'b0;
    we    = 1'b0;
    adr   = BASE_ADDRESS + OPS_OFF;
    wdata = 32'h0;
    case (st)
      S_IDLE: if (start) nxt = S_ON;
      S_ON: begin
        req   = 1'b1;
        we    = 1'b1;
        wdata = 32'h1 << OPS_ON;
        if (ack_done) nxt = S_MSG;
      end
      S_MSG: begin
        req   = 1'b1;
        we    = 1'b1;
        adr   = BASE_ADDRESS + MSG_OFF;
        wdata = msg_q[{idx, 5'd0} +: 32];
        if (ack_done && idx == 4'd15) nxt = S_POLL;
      end
      S_POLL: begin
        req = 1'b1;
        if (ack_done && rdata[OPS_DONE]) nxt = S_DIG;
        else if (poll_abort)             nxt = S_IDLE;
      end
      S_DIG: begin
        req = 1'b1;
        adr = BASE_ADDRESS + DIGEST_OFF;
        if (ack_done && idx == 4'd4) nxt = S_FIN;
      end
      S_FIN:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (timeout) nxt = S_IDLE;
  end

  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      error_code <= ERR_NONE;
      digest_o   <= '0;
      dig_q      <= '0;
      msg_q      <= '0;
      idx        <= '0;
      poll_cnt   <= '0;
    end else begin
      case (st)
        S_IDLE: if (start) begin
          msg_q      <= msg_i;
          busy       <= 1'b1;
          done       <= 1'b0;
          error      <= 1'b0;
          error_code <= ERR_NONE;
          idx        <= '0;
          poll_cnt   <= '0;
        end
        S_MSG:  if (ack_done) idx <= idx + 1'b1;  // wraps to 0 for the digest reads
        S_POLL: if (ack_done && !rdata[OPS_DONE]) poll_cnt <= poll_cnt + 1'b1;
        S_DIG: if (ack_done) begin
          dig_q[{idx[2:0], 5'd0} +: 32] <= rdata;
          idx <= idx + 1'b1;
        end
        S_FIN: begin
          // staged so an abort mid-readback leaves the previous digest visible
          digest_o <= dig_q;
          done     <= 1'b1;
          busy     <= 1'b0;
        end
        default: ;
      endcase
      if (timeout || poll_abort) begin
        busy       <= 1'b0;
        error      <= 1'b1;
        error_code <= timeout ? ERR_ACK_TIMEOUT : ERR_POLL_LIMIT;
      end
    end
  end
endmodule

// File: tb/tb_sha1_wb_host.sv
// Randomized scoreboard bench for sha1_wb_host against a register-level target model.
module tb_sha1_wb_host;
  localparam logic [31:0] BASE   = 32'h3000_0024;
  localparam logic [31:0] A_OPS  = BASE + 32'h8;
  localparam logic [31:0] A_MSG  = BASE + 32'hC;
  localparam logic [31:0] A_DIG  = BASE + 32'h10;
  localparam int          PL     = 4;
  localparam int          ACK_TO = 16;

  typedef struct { bit we; logic [31:0] adr; logic [31:0] dat; } exp_t;
  typedef struct { bit done; bit err; logic [1:0] code; logic [159:0] dig; int lat; } res_t;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [511:0] msg_i;
  logic         busy, done, error;
  logic [1:0]   error_code;
  logic [159:0] digest_o;

  sha1_wb_host_if wb();

  sha1_wb_host #(.BASE_ADDRESS(BASE), .ACK_TIMEOUT(ACK_TO), .POLL_LIMIT(PL)) dut (
    .wb_clk_i(clk), .reset(reset), .start(start), .msg_i(msg_i),
    .busy(busy), .done(done), .error(error), .error_code(error_code),
    .digest_o(digest_o), .wb(wb)
  );

  always #5 clk = ~clk;

  int cycle_n = 0;
  always @(posedge clk) cycle_n <= cycle_n + 1;

  int   n_cmp = 0, n_bad = 0;
  exp_t exp_q[$];
  res_t res_q[$];
  int   t_start;
  logic [159:0] last_dig = '0;

  // target model configuration, rewritten between runs
  int           cfg_dpoll, cfg_silent, cfg_dmode;
  bit           cfg_stray;
  logic [159:0] cfg_dig;
  int           xfer_n, poll_seen, dig_n;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle_n);
    end
  endtask

  // target: logs each strobe into the scoreboard, acks after a chosen delay
  initial begin : target
    bit pend, silent_now, prev_cyc;
    int cnt, len, exp_len;
    exp_t cur, e;
    logic [31:0] rd;
    wb.wbm_ack_i = 1'b0; wb.wbm_dat_i = 32'h0;
    pend = 0; prev_cyc = 0; len = 0; cnt = 0; exp_len = 0; rd = 0;
    cur = '{0, 0, 0};
    forever begin
      @(posedge clk); #1;
      wb.wbm_ack_i = 1'b0;
      if (reset) begin
        pend = 0; prev_cyc = 0; len = 0;
      end else begin
        if (prev_cyc && !wb.wbm_cyc_o) check("cyc_len", len, exp_len);
        if (!wb.wbm_cyc_o) begin
          pend = 0; len = 0;
          if (cfg_stray && $urandom_range(0, 3) == 0) begin
            wb.wbm_ack_i = 1'b1; wb.wbm_dat_i = $urandom;
          end
        end else begin
          len++;
          if (wb.wbm_stb_o) begin
            check("stb_after_idle", prev_cyc, 0);
            check("sel", wb.wbm_sel_o, 4'hF);
            cur = '{wb.wbm_we_o, wb.wbm_adr_o, wb.wbm_dat_o};
            if (exp_q.size() == 0) check("xfer_unexpected", wb.wbm_adr_o, 0);
            else begin
              e = exp_q.pop_front();
              check("xfer_we", cur.we, e.we);
              check("xfer_adr", cur.adr, e.adr);
              if (e.we) check("xfer_dat", cur.dat, e.dat);
            end
            rd = $urandom;
            if (!cur.we && cur.adr == A_OPS) begin
              poll_seen++;
              rd[3] = (cfg_dpoll != 0 && poll_seen == cfg_dpoll);
            end else if (!cur.we && cur.adr == A_DIG) begin
              rd = cfg_dig[32*(dig_n%5) +: 32];
              dig_n++;
            end
            silent_now = (xfer_n == cfg_silent);
            xfer_n++;
            cnt = (cfg_dmode < 0) ? $urandom_range(0, 3) : cfg_dmode;
            exp_len = silent_now ? ACK_TO + 1 : cnt + 1;
            pend = !silent_now;
          end else begin
            check("hold", {wb.wbm_we_o, wb.wbm_adr_o, wb.wbm_dat_o}, {cur.we, cur.adr, cur.dat});
          end
          if (pend) begin
            if (cnt == 0) begin
              wb.wbm_ack_i = 1'b1; wb.wbm_dat_i = rd; pend = 0;
            end else cnt--;
          end
        end
        prev_cyc = wb.wbm_cyc_o;
      end
    end
  end

  // result monitor: compares the sticky outputs whenever a sequence ends
  initial begin : res_mon
    bit pb;
    res_t r;
    pb = 0;
    forever begin
      @(posedge clk); #1;
      if (!reset && pb && !busy) begin
        if (res_q.size() == 0) check("res_unexpected", done, 0);
        else begin
          r = res_q.pop_front();
          check("done", done, r.done);
          check("error", error, r.err);
          check("error_code", error_code, r.code);
          check("digest", digest_o, r.dig);
          if (r.lat >= 0) check("latency", cycle_n - t_start, r.lat);
        end
      end
      pb = busy;
    end
  end

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // reference: register sequence the host must issue, and the outcome
  task automatic start_run(input logic [511:0] m, input logic [159:0] dw, input int dpoll,
                           input int silent, input int dmode, input bit stray, input bit lat_chk);
    exp_t lst[$];
    int np;
    bit ok;
    logic [1:0] code;
    res_t r;
    ok = 1; code = 0;
    lst.push_back('{1, A_OPS, 32'h1});
    for (int k = 0; k < 16; k++) lst.push_back('{1, A_MSG, m[32*k +: 32]});
    if (dpoll >= 1 && dpoll <= PL) np = dpoll;
    else begin np = PL; ok = 0; code = 2; end
    for (int p = 0; p < np; p++) lst.push_back('{0, A_OPS, 32'h0});
    if (ok) for (int j = 0; j < 5; j++) lst.push_back('{0, A_DIG, 32'h0});
    if (silent >= 0 && silent < lst.size()) begin
      while (lst.size() > silent + 1) void'(lst.pop_back());
      ok = 0; code = 1;
    end
    cfg_dpoll = dpoll; cfg_silent = silent; cfg_dmode = dmode; cfg_stray = stray;
    cfg_dig = dw; xfer_n = 0; poll_seen = 0; dig_n = 0;
    foreach (lst[i]) exp_q.push_back(lst[i]);
    r.done = ok; r.err = !ok; r.code = ok ? 2'd0 : code;
    r.dig  = ok ? dw : last_dig;
    r.lat  = (ok && lat_chk) ? 1 + 3 * (22 + np) : -1;
    if (ok) last_dig = dw;
    res_q.push_back(r);
    msg_i = m; start = 1'b1;
    @(posedge clk); #1;
    t_start = cycle_n; start = 1'b0;
    check("busy_rise", busy, 1);
    check("done_cleared", done, 0);
    check("error_cleared", {error, error_code}, 0);
  endtask

  // waits out the sequence while throwing ignored starts and msg_i changes at it
  task automatic finish_run();
    int n;
    n = 0;
    while (busy && n < 2000) begin
      start = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) msg_i = {16{$urandom}};
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check("sequence_ends", busy, 0);
    repeat (2) @(posedge clk); #1;
    check("log_drained", exp_q.size(), 0);
    check("result_drained", res_q.size(), 0);
  endtask

  function automatic logic [511:0] rnd_msg();
    logic [511:0] m;
    for (int k = 0; k < 16; k++) m[32*k +: 32] = $urandom;
    return m;
  endfunction

  function automatic logic [159:0] rnd_dig();
    logic [159:0] d;
    for (int j = 0; j < 5; j++) d[32*j +: 32] = $urandom;
    return d;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"}, {busy, done, error, error_code}, 0);
    check({tag, "_digest"}, digest_o, 0);
    check({tag, "_bus_ctl"}, {wb.wbm_cyc_o, wb.wbm_stb_o, wb.wbm_we_o, wb.wbm_sel_o}, 0);
    check({tag, "_bus_adr_dat"}, {wb.wbm_adr_o, wb.wbm_dat_o}, 0);
  endtask

  initial begin : stim
    logic [511:0] m;
    logic [159:0] nom_dig;
    int n;
    reset = 1'b1; start = 1'b0; msg_i = '0;
    cfg_dpoll = 0; cfg_silent = -1; cfg_dmode = 1; cfg_stray = 0; cfg_dig = '0;
    xfer_n = 0; poll_seen = 0; dig_n = 0;
    repeat (3) @(posedge clk); #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // nominal block, DONE on the third poll
    for (int k = 0; k < 16; k++) m[32*k +: 32] = 32'h1000_0000 + k;
    nom_dig = {32'h9CD0D89D, 32'h7850C26C, 32'hBA3E2571, 32'h4706816A, 32'hA9993E36};
    start_run(m, nom_dig, 3, -1, 1, 0, 1);
    finish_run();
    check("digest_word0", digest_o[31:0], 32'hA9993E36);

    // restart after done with a fresh message
    start_run(rnd_msg(), rnd_dig(), 1, -1, 1, 0, 1);
    finish_run();

    // target silent on MSG word 5
    start_run(rnd_msg(), rnd_dig(), 2, 6, 1, 0, 0);
    finish_run();

    // poll limit: never done, done exactly at the limit, done one past it
    start_run(rnd_msg(), rnd_dig(), 0, -1, 1, 0, 0);
    finish_run();
    start_run(rnd_msg(), rnd_dig(), PL, -1, 1, 0, 1);
    finish_run();
    start_run(rnd_msg(), rnd_dig(), PL + 1, -1, 1, 1, 0);
    finish_run();

    // ack in the strobe cycle, then randomized mixes
    start_run(rnd_msg(), rnd_dig(), 2, -1, 0, 1, 0);
    finish_run();
    for (int i = 0; i < 16; i++) begin
      int dp, sl, dm;
      dp = $urandom_range(0, PL + 1);
      sl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 30) : -1;
      dm = $urandom_range(0, 4) - 1;
      start_run(rnd_msg(), rnd_dig(), dp, sl, dm, $urandom_range(0, 1), 0);
      finish_run();
    end

    // reset while waiting for an ack
    start_run(rnd_msg(), rnd_dig(), 2, -1, 3, 0, 0);
    n = 0;
    while (!(xfer_n >= 5 && wb.wbm_cyc_o && !wb.wbm_stb_o) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    check("reached_ack_wait", wb.wbm_cyc_o && !wb.wbm_stb_o, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_all_zero("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete(); res_q.delete();
    last_dig = '0;
    @(posedge clk); #1;
    start_run(rnd_msg(), rnd_dig(), 3, -1, 1, 0, 1);
    finish_run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
